// File: rtl/demux4_dispatch_ctrl.sv
// demux4_dispatch_ctrl: steers a valid/ready stream onto one of four
// channels through a single registered holding stage.
module demux4_dispatch_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [1:0]        fix_sel,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        out_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic [1:0]        rr_ptr,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       full;
  logic       consume;
  logic       accept;
  logic [1:0] tgt;

  assign full     = (state_q == HOLD);
  assign consume  = full & out_ready[sel];
  assign in_ready = ~rst & ~flush & (~full | consume);
  assign accept   = in_valid & in_ready;
  assign tgt      = mode ? fix_sel : rr_ptr;

  assign out_valid = full ? (4'b0001 << sel) : 4'b0000;

  // Holding-stage occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy: a new beat always wins; otherwise drain or flush empties.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = HOLD;
        end else if (consume | flush) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Capture payload and target only on accept so a held beat never moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      sel      <= 2'd0;
    end else if (accept) begin
      out_data <= in_data;
      sel      <= tgt;
    end
  end

  // Round-robin pointer advances only for beats it actually steered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (flush) begin
      rr_ptr <= 2'd0;
    end else if (accept && !mode) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  // Delivered-beat counter; a consume during flush still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (consume) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule
